// File: rtl/temp_count_reader_if.sv
// temp_count_reader_if: measurement request and result handshake bundle
interface temp_count_reader_if #(
  parameter int WIDTH    = 8,
  parameter int WINDOW_W = 16
);
  logic                start;
  logic [WINDOW_W-1:0] window_len;
  logic                result_ready;
  logic [WIDTH-1:0]    result;
  logic                result_valid;
  logic                overflow;
  logic                busy;
  modport master (output start, window_len, result_ready, input result, result_valid, overflow, busy);
  modport slave  (input start, window_len, result_ready, output result, result_valid, overflow, busy);
endinterface

// File: rtl/temp_count_reader.sv
// temp_count_reader: counts synchronized osc_in rising edges over a programmable clk window.
// Define TEMP_READER_AVG_EN to average four back-to-back windows per request.
module temp_count_reader #(
  parameter int WIDTH       = 8,
  parameter int WINDOW_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset_n,
  input logic               osc_in,
  temp_count_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, osc_rise, accept, last, win_end;
  logic [WINDOW_W-1:0] win_len, timer;
  logic [WIDTH-1:0] cnt, cnt_nxt, res_fin, result_q;
  logic ovf, ovf_nxt, overflow_q;
  assign osc_rise = sync[SYNC_STAGES-1] & ~prev;
  assign accept   = state == IDLE && bus.start && bus.window_len != '0;
  assign last     = state == MEASURE && timer == win_len - WINDOW_W'(1);
  // saturate instead of wrapping; a dropped edge marks the overflow
  assign cnt_nxt  = (osc_rise && !(&cnt)) ? cnt + WIDTH'(1) : cnt;
  assign ovf_nxt  = ovf | (osc_rise & (&cnt));
`ifdef TEMP_READER_AVG_EN
  logic [1:0] win_idx;
  logic [WIDTH+1:0] acc, acc_nxt;
  assign acc_nxt = acc + (WIDTH+2)'(cnt_nxt);
  assign res_fin = acc_nxt[WIDTH+1:2];
  assign win_end = last && win_idx == 2'd3;
  always_ff @(posedge clk)
    if (!reset_n) begin
      win_idx <= '0;
      acc     <= '0;
    end else if (accept) begin
      win_idx <= '0;
      acc     <= '0;
    end else if (last) begin
      win_idx <= win_idx + 2'd1;
      acc     <= acc_nxt;
    end
`else
  assign res_fin = cnt_nxt;
  assign win_end = last;
`endif
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = accept ? MEASURE :
                win_end ? DONE :
                (state == DONE && bus.result_ready) ? IDLE : state;
  always_comb begin
    bus.busy         = state != IDLE;
    bus.result_valid = state == DONE;
    bus.result       = result_q;
    bus.overflow     = overflow_q;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      sync       <= '0;
      prev       <= 1'b0;
      win_len    <= '0;
      timer      <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc_in};
      prev <= sync[SYNC_STAGES-1];
      if (accept) begin
        win_len <= bus.window_len;
        timer   <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else if (state == MEASURE) begin
        timer <= last ? '0 : timer + WINDOW_W'(1);
        cnt   <= last ? '0 : cnt_nxt;
        ovf   <= ovf_nxt;
        if (win_end) begin
          result_q   <= res_fin;
          overflow_q <= ovf_nxt;
        end
      end
    end
endmodule

// File: tb/tb_temp_count_reader.sv
// tb_temp_count_reader: directed vectors with a scoreboard-driven result monitor.
module tb_temp_count_reader;
  localparam int WIDTH = 8, WINDOW_W = 16;
`ifdef TEMP_READER_AVG_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 1;
`endif
  typedef struct {int res; int ovf; int lat; int acc_cyc;} exp_t;
  logic clk = 1'b0, reset_n = 1'b0, osc = 1'b0, v_q = 1'b0;
  int osc_per = 0, ph = 0, cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  temp_count_reader_if #(.WIDTH(WIDTH), .WINDOW_W(WINDOW_W)) bus();
  temp_count_reader #(.WIDTH(WIDTH), .WINDOW_W(WINDOW_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .osc_in(osc), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    ph  <= ph + 1;
    osc <= osc_per != 0 && (ph % osc_per) < osc_per / 2;
  end
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.result_valid && !v_q) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(bus.result), e.res);
        chk("overflow", int'(bus.overflow), e.ovf);
        chk("latency", cyc - e.acc_cyc + 1, e.lat);
      end
    end
    v_q = bus.result_valid;
  end
  task automatic set_osc(int per);
    @(negedge clk);
    osc_per = per;
    repeat (10) @(negedge clk);
  endtask
  task automatic issue(int wl, int res, int ovf);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.window_len = WINDOW_W'(wl);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.res = res;
    e.ovf = ovf;
    e.lat = NWIN * wl + 1;
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_in_time", int'(bus.busy), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic stable;
    bus.start = 1'b0;
    bus.window_len = '0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", int'(bus.result), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clk) reset_n = 1'b1;
    set_osc(8);
    issue(80, 10, 0);
    wait_idle(NWIN * 80 + 20);
    set_osc(4);
    issue(2000, 255, 1);
    wait_idle(NWIN * 2000 + 20);
    set_osc(8);
    issue(100, 0, 0);
    repeat (30) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_result", int'(bus.result), 0);
    chk("midrst_valid", int'(bus.result_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_overflow", int'(bus.overflow), 0);
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    set_osc(0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.window_len = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("zero_len_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_len_idle", int'(bus.busy), 0);
    chk("zero_len_valid", int'(bus.result_valid), 0);
    issue(1, 0, 0);
    wait_idle(20);
    set_osc(8);
    bus.result_ready = 1'b0;
    issue(80, 10, 0);
    n = 0;
    while (!bus.result_valid && n < NWIN * 80 + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_valid_seen", int'(bus.result_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = (i == 10);
      bus.window_len = 16'd50;
      @(posedge clk);
      #1;
      if (bus.result !== 8'd10 || bus.result_valid !== 1'b1 || bus.busy !== 1'b1) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", int'(bus.result_valid), 0);
    chk("hs_busy", int'(bus.busy), 0);
    chk("hs_result_kept", int'(bus.result), 10);
    repeat (5) @(posedge clk);
    #1;
    chk("start_not_queued", int'(bus.busy), 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
